// File: rtl/piso_16.sv
// piso_16: parallel-in/serial-out reader for a register word.
// A word is accepted through a valid/ready load handshake in IDLE. It is then
// streamed one bit per accepted serial transfer, with a flag on the final bit.
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   d_in, load_valid        parallel word and its valid strobe
//   load_ready              high only in IDLE
//   ser_data, ser_valid     current serial bit and its valid flag
//   ser_ready               consumer takes ser_data this cycle
//   ser_last                current bit is the final bit of the word
//   busy                    a word is in flight
module piso_16 #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: shift register and remaining-bit counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load_valid) begin
          sreg_nxt  = d_in;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          // Zero fill: once the last bit leaves, the register is empty again
          sreg_nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only; no path from ser_ready/load_valid
  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign ser_valid  = (state == SHIFT);
  assign ser_last   = (state == SHIFT) && (cnt == '0);
  assign ser_data   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: tb/tb_piso_16.sv
// tb_piso_16: self-checking bench for piso_16 (MSB-first and LSB-first instances).
module tb_piso_16;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] d_in;
  logic        lv_m, lv_l, ser_ready;
  logic        lr_m, sd_m, sv_m, sl_m, bz_m;
  logic        lr_l, sd_l, sv_l, sl_l, bz_l;

  int errors = 0;
  int checks = 0;

  piso_16 #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_m (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(d_in), .load_valid(lv_m),
    .load_ready(lr_m), .ser_data(sd_m), .ser_valid(sv_m), .ser_ready(ser_ready),
    .ser_last(sl_m), .busy(bz_m)
  );

  piso_16 #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_l (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(d_in), .load_valid(lv_l),
    .load_ready(lr_l), .ser_data(sd_l), .ser_valid(sv_l), .ser_ready(ser_ready),
    .ser_last(sl_l), .busy(bz_l)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // {load_ready, ser_data, ser_valid, ser_last, busy} of the selected instance
  function automatic logic [4:0] outs(input bit lsb);
    return lsb ? {lr_l, sd_l, sv_l, sl_l, bz_l} : {lr_m, sd_m, sv_m, sl_m, bz_m};
  endfunction

  // Reference: transfer i carries word bit (15-i) MSB-first, bit i LSB-first
  function automatic logic exp_bit(input logic [15:0] w, input bit lsb, input int i);
    return lsb ? w[i] : w[15-i];
  endfunction

  // Accept a word; ends at the negedge where the first bit should be visible.
  // With offer set, keeps load_valid high with 16'hFFFF on d_in afterwards.
  task automatic load(input bit lsb, input logic [15:0] w, input bit offer);
    logic [4:0] o;
    @(negedge clk_in);
    o = outs(lsb);
    chk("load_ready_before_accept", 32'(o[4]), 32'd1);
    d_in = w;
    if (lsb) lv_l = 1'b1; else lv_m = 1'b1;
    @(negedge clk_in);
    if (offer) begin
      d_in = 16'hFFFF;
    end else begin
      lv_m = 1'b0;
      lv_l = 1'b0;
      d_in = 16'($urandom);
    end
    o = outs(lsb);
    chk("valid_cycle_after_accept", 32'(o[2]), 32'd1);
    chk("busy_cycle_after_accept", 32'(o[0]), 32'd1);
    chk("load_ready_low_in_shift", 32'(o[4]), 32'd0);
  endtask

  // mode 0: ready always high; mode 1: stall 5 cycles after 4 transfers then random ready.
  // Stops after nstop transfers; for a full word also checks the return to IDLE.
  task automatic stream(input bit lsb, input logic [15:0] w, input int mode, input int nstop);
    logic [4:0]  o;
    logic [15:0] reasm = '0;
    int          idx = 0;
    int          stall = 0;
    logic        r;
    logic        prev_d = 1'b0;
    logic        prev_r = 1'b1;
    for (int c = 0; c < 300 && idx < nstop; c++) begin
      o = outs(lsb);
      if (mode == 0) r = 1'b1;
      else if (idx == 4 && stall < 5) begin r = 1'b0; stall++; end
      else if (idx < 4) r = 1'b1;
      else r = 1'($urandom_range(0, 1));
      ser_ready = r;
      chk("ser_valid_in_word", 32'(o[2]), 32'd1);
      chk("ser_data_bit", 32'(o[3]), 32'(exp_bit(w, lsb, idx)));
      chk("ser_last_flag", 32'(o[1]), 32'(idx == 15));
      if (!prev_r) chk("ser_data_held_on_stall", 32'(o[3]), 32'(prev_d));
      if (lv_m && !lsb) chk("load_ready_low_while_offered", 32'(o[4]), 32'd0);
      if (r) begin
        if (lsb) reasm[idx] = o[3]; else reasm[15-idx] = o[3];
        idx++;
      end
      prev_d = o[3];
      prev_r = r;
      @(negedge clk_in);
    end
    chk("transfer_count", 32'(idx), 32'(nstop));
    if (nstop == 16) begin
      o = outs(lsb);
      chk("reassembled_word", 32'(reasm), 32'(w));
      chk("idle_ser_valid", 32'(o[2]), 32'd0);
      chk("idle_ser_last", 32'(o[1]), 32'd0);
      chk("idle_busy", 32'(o[0]), 32'd0);
      chk("idle_load_ready", 32'(o[4]), 32'd1);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_load_ready"}, 32'(lr_m), 32'd1);
    chk({tag, "_ser_data"},   32'(sd_m), 32'd0);
    chk({tag, "_ser_valid"},  32'(sv_m), 32'd0);
    chk({tag, "_ser_last"},   32'(sl_m), 32'd0);
    chk({tag, "_busy"},       32'(bz_m), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  o;
    rst_n_in  = 1'b0;
    lv_m      = 1'b1;
    lv_l      = 1'b1;
    d_in      = 16'hFFFF;
    ser_ready = 1'b1;

    // Reset held with load_valid high: nothing captured
    #3 chk_reset_outs("reset_initial");
    repeat (3) @(negedge clk_in);
    chk_reset_outs("reset_with_load_valid");
    lv_m = 1'b0;
    lv_l = 1'b0;
    rst_n_in = 1'b1;

    // MSB-first 16'hA5C3 at full rate
    load(1'b0, 16'hA5C3, 1'b0);
    stream(1'b0, 16'hA5C3, 0, 16);

    // 16'h8001 with a stall after bit 3 and random ready afterwards
    load(1'b0, 16'h8001, 1'b0);
    stream(1'b0, 16'h8001, 1, 16);

    // 16'hFFFF offered during the 16'h0000 word, taken in the following IDLE cycle
    load(1'b0, 16'h0000, 1'b1);
    stream(1'b0, 16'h0000, 0, 16);
    @(negedge clk_in);
    lv_m = 1'b0;
    o = outs(1'b0);
    chk("offered_word_accepted_valid", 32'(o[2]), 32'd1);
    chk("offered_word_first_bit", 32'(o[3]), 32'd1);
    stream(1'b0, 16'hFFFF, 0, 16);

    // Reset after 7 bits of 16'hDEAD, then a clean 16'h1234
    load(1'b0, 16'hDEAD, 1'b0);
    stream(1'b0, 16'hDEAD, 0, 7);
    #2 rst_n_in = 1'b0;
    #1 chk_reset_outs("reset_mid_word");
    lv_m = 1'b1;
    d_in = 16'($urandom);
    repeat (2) @(negedge clk_in);
    chk_reset_outs("reset_hold_mid_word");
    lv_m = 1'b0;
    rst_n_in = 1'b1;
    load(1'b0, 16'h1234, 1'b0);
    stream(1'b0, 16'h1234, 0, 16);

    // LSB-first 16'h0001
    load(1'b1, 16'h0001, 1'b0);
    stream(1'b1, 16'h0001, 0, 16);

    // Random words, random ready, both bit orders
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      load(1'(k % 2), w, 1'b0);
      stream(1'(k % 2), w, 1, 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
